operand_fetch: RTL and testbench

Decode-side read end of the register-file write interface driven by the writeback stage.
- Holds the architectural register file.
- Accepts the W-stage write port.
- Serves two source-operand reads with same-cycle write-through bypass.
- Detects load-use hazards and produces the registered ID/EX operand bundle consumed by execute.

---
 rtl/operand_fetch_pkg.sv | 31 +++
 rtl/operand_fetch_regfile.sv | 41 ++++
 rtl/operand_fetch.sv | 105 ++++++++++
 tb/tb_operand_fetch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch slice:
// default widths, the zero register index and the ID/EX bundle.
package operand_fetch_pkg;

    localparam int OF_DATA_W = 32;
    localparam int OF_ADDR_W = 5;
    localparam int OF_NREGS  = 1 << OF_ADDR_W;

    localparam logic [OF_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                 valid;
        logic [OF_DATA_W-1:0] rdData1;
        logic [OF_DATA_W-1:0] rdData2;
        logic [OF_ADDR_W-1:0] rs;
        logic [OF_ADDR_W-1:0] rt;
        logic [OF_ADDR_W-1:0] rd;
    } id_ex_t;

    localparam id_ex_t EX_BUBBLE = '0;

    // True when an enabled producer targets a non-zero index matching a reader.
    function automatic logic idx_hit(
        input logic                 en,
        input logic [OF_ADDR_W-1:0] prod,
        input logic [OF_ADDR_W-1:0] cons
    );
        return en && (prod == cons) && (prod != ZERO_REG);
    endfunction

endpackage

// File: rtl/operand_fetch_regfile.sv
// Architectural register file: one synchronous write port,
// two asynchronous read ports, index 0 hardwired to zero.
module regfile_2r1w
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = OF_DATA_W,
    parameter int ADDR_W = OF_ADDR_W,
    parameter int NREGS  = OF_NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_mem [NREGS];

    logic w_wr_ok;

    assign w_wr_ok = i_we && (i_waddr != '0);

    // Clear every entry on reset; otherwise commit non-zero-index writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/operand_fetch.sv
// Decode-side operand fetch: register file reads with W-stage
// write-through bypass, load-use stall detection and the ID/EX register.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = OF_DATA_W,
    parameter int ADDR_W = OF_ADDR_W,
    parameter int NREGS  = OF_NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              validD,
    input  logic [ADDR_W-1:0] rsD,
    input  logic [ADDR_W-1:0] rtD,
    input  logic [ADDR_W-1:0] rdD,
    input  logic              flushE,
    input  logic              RegWriteW,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic              RegWriteE,
    input  logic              MemToRegE,
    input  logic [ADDR_W-1:0] WriteRegE,
    output logic              stallD,
    output logic              validE,
    output logic [DATA_W-1:0] rdData1E,
    output logic [DATA_W-1:0] rdData2E,
    output logic [ADDR_W-1:0] rsE,
    output logic [ADDR_W-1:0] rtE,
    output logic [ADDR_W-1:0] rdE
);

    logic [DATA_W-1:0] w_rf1;
    logic [DATA_W-1:0] w_rf2;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;
    logic              w_byp1;
    logic              w_byp2;
    logic              w_load_e;
    logic              w_stall;
    logic              w_bubble;
    id_ex_t            w_next;
    id_ex_t            r_ex;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (RegWriteW),
        .i_waddr  (WriteRegW),
        .i_wdata  (ResultW),
        .i_raddr1 (rsD),
        .o_rdata1 (w_rf1),
        .i_raddr2 (rtD),
        .o_rdata2 (w_rf2)
    );

    // A write landing this cycle is visible to this cycle's reads.
    assign w_byp1 = idx_hit(RegWriteW, WriteRegW, rsD);
    assign w_byp2 = idx_hit(RegWriteW, WriteRegW, rtD);

    assign w_src1 = w_byp1 ? ResultW : w_rf1;
    assign w_src2 = w_byp2 ? ResultW : w_rf2;

    // A load in E cannot forward in time to a dependent op in D.
    assign w_load_e = RegWriteE && MemToRegE;
    assign w_stall  = validD && w_load_e &&
                      (idx_hit(1'b1, WriteRegE, rsD) ||
                       idx_hit(1'b1, WriteRegE, rtD));

    assign stallD   = w_stall;
    assign w_bubble = flushE || w_stall;

    // Assemble the bundle that E captures on a normal advance.
    always_comb begin
        w_next         = EX_BUBBLE;
        w_next.valid   = validD;
        w_next.rdData1 = w_src1;
        w_next.rdData2 = w_src2;
        w_next.rs      = rsD;
        w_next.rt      = rtD;
        w_next.rd      = rdD;
    end

    // ID/EX register: reset, then flush/stall bubble, then advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex <= EX_BUBBLE;
        end else if (w_bubble) begin
            r_ex <= EX_BUBBLE;
        end else begin
            r_ex <= w_next;
        end
    end

    assign validE   = r_ex.valid;
    assign rdData1E = r_ex.rdData1;
    assign rdData2E = r_ex.rdData2;
    assign rsE      = r_ex.rs;
    assign rtE      = r_ex.rt;
    assign rdE      = r_ex.rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed cases then random traffic
// checked against an array-based register file model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        validD;
    logic [4:0]  rsD, rtD, rdD;
    logic        flushE;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        RegWriteE;
    logic        MemToRegE;
    logic [4:0]  WriteRegE;
    logic        stallD;
    logic        validE;
    logic [31:0] rdData1E, rdData2E;
    logic [4:0]  rsE, rtE, rdE;

    typedef struct {
        logic        v;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } exp_t;

    exp_t      bq[$];
    logic      sq[$];
    logic [31:0] model [32];
    int        tests = 0;
    int        fails = 0;

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .validD    (validD),
        .rsD       (rsD),
        .rtD       (rtD),
        .rdD       (rdD),
        .flushE    (flushE),
        .RegWriteW (RegWriteW),
        .WriteRegW (WriteRegW),
        .ResultW   (ResultW),
        .RegWriteE (RegWriteE),
        .MemToRegE (MemToRegE),
        .WriteRegE (WriteRegE),
        .stallD    (stallD),
        .validE    (validE),
        .rdData1E  (rdData1E),
        .rdData2E  (rdData2E),
        .rsE       (rsE),
        .rtE       (rtE),
        .rdE       (rdE)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(
        input logic [4:0] a, input logic we,
        input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return model[a];
    endfunction

    task automatic drive(
        input logic rst, input logic v,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic fl, input logic we, input logic [4:0] wa,
        input logic [31:0] wd, input logic rwe, input logic mte,
        input logic [4:0] wre);
        exp_t e;
        logic st;
        @(negedge clk);
        rst_n = rst; validD = v; rsD = rs; rtD = rt; rdD = rd;
        flushE = fl; RegWriteW = we; WriteRegW = wa; ResultW = wd;
        RegWriteE = rwe; MemToRegE = mte; WriteRegE = wre;
        st = v && rwe && mte && wre != 0 && (wre == rs || wre == rt);
        sq.push_back(st);
        e = '{1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0};
        if (rst && !fl && !st) begin
            e.v  = v;
            e.d1 = rd_model(rs, we, wa, wd);
            e.d2 = rd_model(rt, we, wa, wd);
            e.rs = rs; e.rt = rt; e.rd = rd;
        end
        bq.push_back(e);
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && wa != 0) begin
            model[wa] = wd;
        end
    endtask

    task automatic rd_only(input logic [4:0] rs, input logic [4:0] rt);
        drive(1, 1, rs, rt, 5'd1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Stall monitor: checked mid-cycle after the driver settles inputs.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sq.size() > 0) begin
                logic s;
                s = sq.pop_front();
                tests++;
                if (stallD !== s) begin
                    fails++;
                    $display("FAIL stallD got=%0b exp=%0b t=%0t", stallD, s, $time);
                end
            end
        end
    end

    // Bundle monitor: one expectation per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bq.size() > 0) begin
                exp_t e;
                e = bq.pop_front();
                tests++;
                if (validE !== e.v || rdData1E !== e.d1 || rdData2E !== e.d2 ||
                    rsE !== e.rs || rtE !== e.rt || rdE !== e.rd) begin
                    fails++;
                    $display("FAIL bundle got v=%0b d1=%h d2=%h rs=%0d rt=%0d rd=%0d exp v=%0b d1=%h d2=%h rs=%0d rt=%0d rd=%0d t=%0t",
                             validE, rdData1E, rdData2E, rsE, rtE, rdE,
                             e.v, e.d1, e.d2, e.rs, e.rt, e.rd, $time);
                end
            end
        end
    end

    initial begin
        rst_n = 0; validD = 0; rsD = 0; rtD = 0; rdD = 0; flushE = 0;
        RegWriteW = 0; WriteRegW = 0; ResultW = 0;
        RegWriteE = 0; MemToRegE = 0; WriteRegE = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'hx;

        // Reset with a write that must be ignored.
        drive(0, 1, 3, 7, 2, 0, 1, 3, 32'hAAAA5555, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rd_only(3, 7);
        // Write then read next cycle.
        drive(1, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        rd_only(5, 0);
        // Same-cycle bypass on both operands.
        drive(1, 1, 9, 9, 4, 0, 1, 9, 32'h12345678, 0, 0, 0);
        // Zero register write and bypass suppression.
        drive(1, 1, 0, 0, 6, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        rd_only(0, 9);
        // Load-use stall with simultaneous W write, then release.
        drive(1, 1, 1, 4, 7, 0, 1, 4, 32'hCAFE0004, 1, 1, 4);
        drive(1, 1, 1, 4, 7, 0, 0, 0, 0, 1, 0, 4);
        // Flush priority over a valid read; non-hazard on index 0.
        drive(1, 0, 0, 0, 0, 0, 1, 2, 32'h55, 0, 0, 0);
        drive(1, 1, 2, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 2, 0, 3, 0, 0, 0, 0, 1, 1, 0);
        // Flush and stall together.
        drive(1, 1, 8, 2, 3, 1, 0, 0, 0, 1, 1, 8);

        // Random traffic, small index range to force collisions.
        for (int n = 0; n < 600; n++) begin
            logic rst;
            rst = ($urandom_range(0, 99) != 0);
            drive(rst, 1'($urandom), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom),
                  ($urandom_range(0, 9) == 0),
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom), ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 7)));
        end

        @(negedge clk);
        repeat (2) @(posedge clk);
        #3;
        tests++;
        if (bq.size() != 0 || sq.size() != 0) begin
            fails++;
            $display("FAIL drain got bq=%0d sq=%0d exp 0", bq.size(), sq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
